// File: rtl/rcc_rst_seq.sv
// Reset sequencer for the rcc: filters PLL lock, releases N_CH active-low domain
// resets in a staggered order, and handles lock loss and per-channel software resets.
module rcc_rst_seq #(
    parameter int N_CH        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILT   = 16,
    parameter int STAGGER     = 4,
    parameter int SW_HOLD     = 8
) (
    input  logic            sys_root_clk,
    input  logic            sys_root_rst,
    input  logic            pll_locked,
    input  logic [N_CH-1:0] sw_rst_req,
    input  logic            sticky_clr,
    output logic [N_CH-1:0] ch_rstn,
    output logic            seq_done,
    output logic            lock_lost,
    output logic [1:0]      state
);

    localparam int FW = $clog2(LOCK_FILT + 1);
    localparam int SW = $clog2(STAGGER + 1);
    localparam int HW = $clog2(SW_HOLD + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 cur_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [FW-1:0]          filt_cnt;
    logic [SW-1:0]          stag_cnt;
    logic [HW-1:0]          hold_cnt [N_CH];
    logic [N_CH-1:0]        rel_next;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign state  = cur_state;

    always_ff @(posedge sys_root_clk or posedge sys_root_rst) begin
        if (sys_root_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Released channels always form a run of ones from bit 0, so the next
    // channel to release is found by shifting that run up by one.
    always_comb begin
        rel_next = (ch_rstn << 1) | N_CH'(1);
    end

    always_ff @(posedge sys_root_clk or posedge sys_root_rst) begin
        if (sys_root_rst) begin
            cur_state <= WAIT_LOCK;
            filt_cnt  <= '0;
            stag_cnt  <= '0;
            ch_rstn   <= '0;
            seq_done  <= 1'b0;
            lock_lost <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                hold_cnt[k] <= '0;
            end
        end else begin
            if (sticky_clr) begin
                lock_lost <= 1'b0;
            end
            // A lock-loss set below overrides a sticky_clr in the same cycle.
            if (!lock_s && (cur_state == RELEASE || cur_state == RUN)) begin
                cur_state <= WAIT_LOCK;
                filt_cnt  <= '0;
                stag_cnt  <= '0;
                ch_rstn   <= '0;
                seq_done  <= 1'b0;
                lock_lost <= 1'b1;
                for (int k = 0; k < N_CH; k++) begin
                    hold_cnt[k] <= '0;
                end
            end else begin
                case (cur_state)
                    WAIT_LOCK: begin
                        filt_cnt <= '0;
                        if (lock_s) begin
                            cur_state <= FILTER;
                        end
                    end
                    FILTER: begin
                        if (!lock_s) begin
                            cur_state <= WAIT_LOCK;
                            filt_cnt  <= '0;
                        end else if (filt_cnt == FW'(LOCK_FILT - 1)) begin
                            filt_cnt   <= '0;
                            stag_cnt   <= '0;
                            ch_rstn[0] <= 1'b1;
                            if (N_CH == 1) begin
                                cur_state <= RUN;
                                seq_done  <= 1'b1;
                            end else begin
                                cur_state <= RELEASE;
                            end
                        end else begin
                            filt_cnt <= filt_cnt + FW'(1);
                        end
                    end
                    RELEASE: begin
                        if (stag_cnt == SW'(STAGGER - 1)) begin
                            stag_cnt <= '0;
                            ch_rstn  <= rel_next;
                            if (&rel_next) begin
                                seq_done  <= 1'b1;
                                cur_state <= RUN;
                            end
                        end else begin
                            stag_cnt <= stag_cnt + SW'(1);
                        end
                    end
                    RUN: begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (sw_rst_req[k]) begin
                                hold_cnt[k] <= HW'(SW_HOLD);
                                ch_rstn[k]  <= 1'b0;
                            end else if (hold_cnt[k] != '0) begin
                                hold_cnt[k] <= hold_cnt[k] - HW'(1);
                                ch_rstn[k]  <= (hold_cnt[k] == HW'(1));
                            end else begin
                                ch_rstn[k] <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        cur_state <= WAIT_LOCK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rcc_rst_seq.sv
// Testbench for rcc_rst_seq: a 3-channel and a 1-channel instance checked against a
// time-based reference model plus fixed timing expectations for the release sequence.
module tb_rcc_rst_seq;

    localparam int N_CH        = 3;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_FILT   = 16;
    localparam int STAGGER     = 4;
    localparam int SW_HOLD     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            pll;
    logic            clr;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] ch;
    logic            done;
    logic            ll;
    logic [1:0]      st;

    logic [0:0]      sw_a;
    logic            clr_a;
    logic [0:0]      ch_a;
    logic            done_a;
    logic            ll_a;
    logic [1:0]      st_a;

    int errors = 0;
    int checks = 0;

    rcc_rst_seq #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .LOCK_FILT(LOCK_FILT),
        .STAGGER(STAGGER), .SW_HOLD(SW_HOLD)
    ) dut (
        .sys_root_clk(clk),
        .sys_root_rst(rst),
        .pll_locked(pll),
        .sw_rst_req(sw),
        .sticky_clr(clr),
        .ch_rstn(ch),
        .seq_done(done),
        .lock_lost(ll),
        .state(st)
    );

    rcc_rst_seq #(
        .N_CH(1), .SYNC_STAGES(SYNC_STAGES), .LOCK_FILT(LOCK_FILT),
        .STAGGER(STAGGER), .SW_HOLD(SW_HOLD)
    ) dut_one (
        .sys_root_clk(clk),
        .sys_root_rst(rst),
        .pll_locked(pll),
        .sw_rst_req(sw_a),
        .sticky_clr(clr_a),
        .ch_rstn(ch_a),
        .seq_done(done_a),
        .lock_lost(ll_a),
        .state(st_a)
    );

    // Reference model: index 0 follows the 3-channel instance, index 1 the 1-channel one.
    // Release and hold timing is kept as absolute edge numbers rather than counters.
    int                     cyc = 0;
    logic [SYNC_STAGES-1:0] m_sync = '0;
    int                     m_ph [2];
    bit                     m_rel [2];
    bit                     m_ll [2];
    int                     m_fstart [2];
    int                     m_rstart [2];
    int                     m_hold_end [N_CH];

    always @(posedge clk or posedge rst) begin
        bit ls;
        int nch;
        bit clr_m;
        if (rst) begin
            m_sync = '0;
            for (int m = 0; m < 2; m++) begin
                m_ph[m]  = 0;
                m_rel[m] = 1'b0;
                m_ll[m]  = 1'b0;
            end
            for (int k = 0; k < N_CH; k++) m_hold_end[k] = 0;
        end else begin
            cyc++;
            ls     = m_sync[SYNC_STAGES-1];
            m_sync = {m_sync[SYNC_STAGES-2:0], pll};
            for (int m = 0; m < 2; m++) begin
                nch   = (m == 0) ? N_CH : 1;
                clr_m = (m == 0) ? clr : 1'b0;
                if (clr_m) m_ll[m] = 1'b0;
                case (m_ph[m])
                    0: begin
                        if (ls) begin
                            m_ph[m]     = 1;
                            m_fstart[m] = cyc;
                        end
                    end
                    1: begin
                        if (!ls) begin
                            m_ph[m] = 0;
                        end else if (cyc - m_fstart[m] == LOCK_FILT) begin
                            m_rel[m]    = 1'b1;
                            m_rstart[m] = cyc;
                            m_ph[m]     = (nch == 1) ? 3 : 2;
                        end
                    end
                    default: begin
                        if (!ls) begin
                            m_ph[m]  = 0;
                            m_rel[m] = 1'b0;
                            m_ll[m]  = 1'b1;
                            if (m == 0) begin
                                for (int k = 0; k < N_CH; k++) m_hold_end[k] = 0;
                            end
                        end else if (m_ph[m] == 2) begin
                            if (cyc - m_rstart[m] == (nch - 1) * STAGGER) m_ph[m] = 3;
                        end else if (m == 0) begin
                            for (int k = 0; k < N_CH; k++) begin
                                if (sw[k]) m_hold_end[k] = cyc + SW_HOLD;
                            end
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [N_CH+3:0] exp_main();
        logic [N_CH-1:0] c;
        for (int k = 0; k < N_CH; k++) begin
            c[k] = m_rel[0] && (cyc >= m_rstart[0] + k * STAGGER) && (cyc >= m_hold_end[k]);
        end
        return {2'(m_ph[0]), m_ll[0], (m_ph[0] == 3), c};
    endfunction

    function automatic logic [4:0] exp_one();
        return {2'(m_ph[1]), m_ll[1], (m_ph[1] == 3), m_rel[1]};
    endfunction

    task automatic test_reset();
        pll = 1'b0; sw = '0; clr = 1'b0; sw_a = '0; clr_a = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({st, ll, done, ch} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_main got=%b exp=%b", {st, ll, done, ch}, 7'b0);
            end
            checks++;
            if ({st_a, ll_a, done_a, ch_a} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_one got=%b exp=%b", {st_a, ll_a, done_a, ch_a}, 5'b0);
            end
        end
    endtask

    task automatic test_startup();
        int t_f = -1, t_c0 = -1, t_c1 = -1, t_c2 = -1, t_d = -1, t_a = -1;
        @(negedge clk);
        rst = 1'b0;
        pll = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if ({st, ll, done, ch} !== exp_main()) begin
                errors++;
                $display("[TB] FAIL startup_main cyc=%0d got=%b exp=%b", cyc, {st, ll, done, ch}, exp_main());
            end
            checks++;
            if ({st_a, ll_a, done_a, ch_a} !== exp_one()) begin
                errors++;
                $display("[TB] FAIL startup_one cyc=%0d got=%b exp=%b", cyc, {st_a, ll_a, done_a, ch_a}, exp_one());
            end
            if (t_f < 0 && st == 2'd1) t_f = i;
            if (t_c0 < 0 && ch[0]) t_c0 = i;
            if (t_c1 < 0 && ch[1]) t_c1 = i;
            if (t_c2 < 0 && ch[2]) t_c2 = i;
            if (t_d < 0 && done) t_d = i;
            if (t_a < 0 && ch_a[0]) t_a = i;
        end
        checks++;
        if (t_f < 0 || t_c0 != t_f + 16) begin
            errors++;
            $display("[TB] FAIL startup_ch0_delay got=%0d exp=16", t_c0 - t_f);
        end
        checks++;
        if (t_c0 < 0 || t_c1 != t_c0 + 4) begin
            errors++;
            $display("[TB] FAIL startup_ch1_delay got=%0d exp=4", t_c1 - t_c0);
        end
        checks++;
        if (t_c1 < 0 || t_c2 != t_c1 + 4) begin
            errors++;
            $display("[TB] FAIL startup_ch2_delay got=%0d exp=4", t_c2 - t_c1);
        end
        checks++;
        if (t_c2 < 0 || t_d != t_c2) begin
            errors++;
            $display("[TB] FAIL startup_done_edge got=%0d exp=%0d", t_d, t_c2);
        end
        checks++;
        if (t_f < 0 || t_a != t_f + 16 || st_a !== 2'd3 || done_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL startup_one_ch_run got=%0d/st%0d exp=%0d/st3", t_a, st_a, t_f + 16);
        end
        checks++;
        if ({st, ll, done, ch} !== 7'b11_0_1_111) begin
            errors++;
            $display("[TB] FAIL startup_final got=%b exp=%b", {st, ll, done, ch}, 7'b1101111);
        end
    endtask

    task automatic test_glitch();
        bit saw_wait = 1'b0;
        int t_f2 = -1, t_c0 = -1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10 && st != 2'd1; i++) @(negedge clk);
        checks++;
        if (st !== 2'd1) begin
            errors++;
            $display("[TB] FAIL glitch_reach_filter got=%0d exp=1", st);
        end
        repeat (10) @(negedge clk);
        pll = 1'b0;
        @(negedge clk);
        pll = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({st, ll, done, ch} !== exp_main()) begin
                errors++;
                $display("[TB] FAIL glitch_main cyc=%0d got=%b exp=%b", cyc, {st, ll, done, ch}, exp_main());
            end
            if (st == 2'd0) saw_wait = 1'b1;
            if (saw_wait && t_f2 < 0 && st == 2'd1) t_f2 = i;
            if (t_c0 < 0 && ch[0]) t_c0 = i;
            if (t_c0 < 0) begin
                checks++;
                if (ch !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL glitch_early_release got=%b exp=000", ch);
                end
            end
        end
        checks++;
        if (!saw_wait || t_f2 < 0 || t_c0 != t_f2 + 16) begin
            errors++;
            $display("[TB] FAIL glitch_refilter got=%0d exp=16 wait=%0d", t_c0 - t_f2, saw_wait);
        end
        checks++;
        if (ll !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_lock_lost got=%b exp=0", ll);
        end
    endtask

    task automatic test_lock_loss_run();
        int t_lost = -1;
        checks++;
        if (st !== 2'd3) begin
            errors++;
            $display("[TB] FAIL loss_precond_run got=%0d exp=3", st);
        end
        @(negedge clk);
        pll = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if ({st, ll, done, ch} !== exp_main()) begin
                errors++;
                $display("[TB] FAIL loss_main cyc=%0d got=%b exp=%b", cyc, {st, ll, done, ch}, exp_main());
            end
            if (t_lost < 0 && ll && ch == 3'b000 && !done) t_lost = i;
        end
        checks++;
        if (t_lost < 1 || t_lost > SYNC_STAGES + 1) begin
            errors++;
            $display("[TB] FAIL loss_latency got=%0d exp<=%0d", t_lost, SYNC_STAGES + 1);
        end
        pll = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({st, ll, done, ch} !== exp_main()) begin
                errors++;
                $display("[TB] FAIL relock_main cyc=%0d got=%b exp=%b", cyc, {st, ll, done, ch}, exp_main());
            end
        end
        checks++;
        if ({st, ll, done, ch} !== 7'b11_1_1_111) begin
            errors++;
            $display("[TB] FAIL relock_final got=%b exp=%b", {st, ll, done, ch}, 7'b1111111);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (ll !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sticky_clear got=%b exp=0", ll);
        end
    endtask

    task automatic test_sw_reset();
        int low = 0, others_bad = 0, done_bad = 0;
        @(negedge clk);
        sw = 3'b010;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sw = '0;
            checks++;
            if ({st, ll, done, ch} !== exp_main()) begin
                errors++;
                $display("[TB] FAIL sw_main cyc=%0d got=%b exp=%b", cyc, {st, ll, done, ch}, exp_main());
            end
            if (!ch[1]) low++;
            if (!ch[0] || !ch[2]) others_bad++;
            if (!done) done_bad++;
        end
        checks++;
        if (low != 8 || others_bad != 0 || done_bad != 0) begin
            errors++;
            $display("[TB] FAIL sw_single_hold got=%0d/%0d/%0d exp=8/0/0", low, others_bad, done_bad);
        end
        low = 0;
        sw = 3'b010;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            sw = (i == 4) ? 3'b010 : 3'b000;
            checks++;
            if ({st, ll, done, ch} !== exp_main()) begin
                errors++;
                $display("[TB] FAIL sw_reload_main cyc=%0d got=%b exp=%b", cyc, {st, ll, done, ch}, exp_main());
            end
            if (!ch[1]) low++;
        end
        checks++;
        if (low != 13) begin
            errors++;
            $display("[TB] FAIL sw_reload_hold got=%0d exp=13", low);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 40 && !ch[0]; i++) @(negedge clk);
        checks++;
        if (st !== 2'd2 || ch !== 3'b001) begin
            errors++;
            $display("[TB] FAIL async_precond got=st%0d/%b exp=st2/001", st, ch);
        end
        checks++;
        if (st_a !== 2'd3 || ch_a !== 1'b1 || done_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL one_ch_direct_run got=st%0d/%b exp=st3/1", st_a, ch_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({st, ll, done, ch} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset_main got=%b exp=0000000", {st, ll, done, ch});
        end
        checks++;
        if ({st_a, ll_a, done_a, ch_a} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset_one got=%b exp=00000", {st_a, ll_a, done_a, ch_a});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_release_ignore_and_collision();
        int t_rel = -1, t_full = -1;
        logic [N_CH-1:0] prev = '0;
        for (int i = 0; i < 60 && t_full < 0; i++) begin
            @(negedge clk);
            checks++;
            if ({st, ll, done, ch} !== exp_main()) begin
                errors++;
                $display("[TB] FAIL ignore_main cyc=%0d got=%b exp=%b", cyc, {st, ll, done, ch}, exp_main());
            end
            checks++;
            if ((prev & ~ch) != '0) begin
                errors++;
                $display("[TB] FAIL ignore_extra_low got=%b exp_set=%b", ch, prev);
            end
            prev = ch;
            if (t_rel < 0 && st == 2'd2) t_rel = i;
            if (ch == 3'b111) t_full = i;
            sw = (st == 2'd2) ? N_CH'($urandom) : '0;
        end
        sw = '0;
        checks++;
        if (t_rel < 0 || t_full != t_rel + 8) begin
            errors++;
            $display("[TB] FAIL ignore_release_timing got=%0d exp=8", t_full - t_rel);
        end
        repeat (3) @(negedge clk);
        pll = 1'b0;
        repeat (SYNC_STAGES) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (ll !== 1'b1 || st !== 2'd0) begin
            errors++;
            $display("[TB] FAIL collision_set_wins got=ll%b/st%0d exp=ll1/st0", ll, st);
        end
        pll = 1'b1;
    endtask

    task automatic test_random();
        int drop_left = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            checks++;
            if ({st, ll, done, ch} !== exp_main()) begin
                errors++;
                $display("[TB] FAIL random_main cyc=%0d got=%b exp=%b", cyc, {st, ll, done, ch}, exp_main());
            end
            checks++;
            if ({st_a, ll_a, done_a, ch_a} !== exp_one()) begin
                errors++;
                $display("[TB] FAIL random_one cyc=%0d got=%b exp=%b", cyc, {st_a, ll_a, done_a, ch_a}, exp_one());
            end
            if (drop_left > 0) begin
                drop_left--;
                pll = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                drop_left = $urandom_range(0, 4);
                pll = 1'b0;
            end else begin
                pll = 1'b1;
            end
            sw  = ($urandom_range(0, 9) == 0) ? N_CH'($urandom) : '0;
            clr = ($urandom_range(0, 24) == 0);
        end
        sw = '0;
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_glitch();
        test_lock_loss_run();
        test_sw_reset();
        test_async_reset();
        test_release_ignore_and_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
